// File: rtl/updown_step_ctrl_pkg.sv
// Shared definitions for the up/down step controller: FSM states, direction
// codes and default counter limits.
package updown_step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        HOLD  = 2'd2,
        LOCK  = 2'd3
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int DEF_CNT_W   = 4;
    localparam int DEF_MAX_VAL = 10;
    localparam int DEF_MIN_VAL = 0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/updown_step_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw
// push-button; the debounced level flips after DEB_CNT agreeing samples.
module btn_debounce_c
    import updown_step_ctrl_pkg::*;
#(
    parameter int DEB_CNT = 1000000
) (
    input  logic clk_c,
    input  logic reset_n_c,
    input  logic btn_raw_c,
    output logic btn_level_c
);

    localparam int CW = max_int($clog2(DEB_CNT), 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_c or negedge reset_n_c) begin
        if (!reset_n_c) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_c;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample agreeing with the debounced level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign btn_level_c = level_q;

endmodule

// File: rtl/updown_step_ctrl.sv
// Button front-end for the saturating up/down counter: debounce, arbitration,
// hold-to-repeat and limit-gated single-cycle step strobes.
module updown_step_ctrl
    import updown_step_ctrl_pkg::*;
#(
    parameter int DEB_CNT   = 1000000,
    parameter int RPT_DELAY = 50000000,
    parameter int RPT_RATE  = 20000000,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_VAL   = DEF_MAX_VAL,
    parameter int MIN_VAL   = DEF_MIN_VAL
) (
    input  logic             clk_c,
    input  logic             reset_n_c,
    input  logic             up_btn_c,
    input  logic             down_btn_c,
    input  logic             enable_n_c,
    input  logic [CNT_W-1:0] level_c,
    output logic             up_pulse_c,
    output logic             down_pulse_c,
    output logic             at_max_c,
    output logic             at_min_c,
    output logic             lockout_c
);

    localparam int TW = max_int($clog2(max_int(RPT_DELAY, RPT_RATE)), 1);
    localparam logic [TW-1:0]    DELAY_LOAD = TW'(RPT_DELAY - 1);
    localparam logic [TW-1:0]    RATE_LOAD  = TW'(RPT_RATE - 1);
    localparam logic [CNT_W-1:0] MAX_L      = CNT_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] MIN_L      = CNT_W'(MIN_VAL);

    logic          btn_u, btn_d;
    logic          held_btn, other_btn;
    logic          step_req;
    state_e        state_q, state_d;
    logic          dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          up_pulse_q, up_pulse_d;
    logic          down_pulse_q, down_pulse_d;
    logic          at_max_q, at_max_d;
    logic          at_min_q, at_min_d;

    btn_debounce_c #(.DEB_CNT(DEB_CNT)) u_deb_up (
        .clk_c       (clk_c),
        .reset_n_c   (reset_n_c),
        .btn_raw_c   (up_btn_c),
        .btn_level_c (btn_u)
    );

    btn_debounce_c #(.DEB_CNT(DEB_CNT)) u_deb_down (
        .clk_c       (clk_c),
        .reset_n_c   (reset_n_c),
        .btn_raw_c   (down_btn_c),
        .btn_level_c (btn_d)
    );

    assign held_btn  = (dir_q == DIR_UP) ? btn_u : btn_d;
    assign other_btn = (dir_q == DIR_UP) ? btn_d : btn_u;

    always_ff @(posedge clk_c or negedge reset_n_c) begin
        if (!reset_n_c) begin
            state_q      <= IDLE;
            dir_q        <= DIR_UP;
            timer_q      <= '0;
            up_pulse_q   <= 1'b0;
            down_pulse_q <= 1'b0;
            at_max_q     <= 1'b0;
            at_min_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            timer_q      <= timer_d;
            up_pulse_q   <= up_pulse_d;
            down_pulse_q <= down_pulse_d;
            at_max_q     <= at_max_d;
            at_min_q     <= at_min_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        timer_d  = timer_q;
        step_req = 1'b0;
        case (state_q)
            IDLE: begin
                if ((btn_u && btn_d) || (enable_n_c && (btn_u || btn_d))) begin
                    state_d = LOCK;
                end else if (btn_u) begin
                    state_d = FIRST;
                    dir_d   = DIR_UP;
                end else if (btn_d) begin
                    state_d = FIRST;
                    dir_d   = DIR_DOWN;
                end
            end
            FIRST: begin
                step_req = 1'b1;
                timer_d  = DELAY_LOAD;
                state_d  = HOLD;
            end
            // Lockout takes priority over release, and both over a repeat step.
            HOLD: begin
                if (enable_n_c || other_btn) begin
                    state_d = LOCK;
                end else if (!held_btn) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    step_req = 1'b1;
                    timer_d  = RATE_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            LOCK: begin
                if (!btn_u && !btn_d && !enable_n_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        up_pulse_d   = step_req && (dir_q == DIR_UP)   && (level_c != MAX_L) && !enable_n_c;
        down_pulse_d = step_req && (dir_q == DIR_DOWN) && (level_c != MIN_L) && !enable_n_c;
        at_max_d     = (level_c == MAX_L);
        at_min_d     = (level_c == MIN_L);
    end

    assign up_pulse_c   = up_pulse_q;
    assign down_pulse_c = down_pulse_q;
    assign at_max_c     = at_max_q;
    assign at_min_c     = at_min_q;
    assign lockout_c    = (state_q == LOCK);

endmodule

// File: tb/tb_updown_step_ctrl.sv
// Scoreboard bench for updown_step_ctrl: a press-level timing model predicts
// every step strobe, and a forked monitor matches strobes against it.
module tb_updown_step_ctrl;

   localparam int DEB_CNT   = 4;
   localparam int RPT_DELAY = 20;
   localparam int RPT_RATE  = 8;
   localparam int CNT_W     = 4;
   localparam int MAX_VAL   = 10;
   localparam int MIN_VAL   = 0;
   // raw press -> first strobe, and raw release -> debounced low
   localparam int FIRST_LAT = 2 + DEB_CNT + 2;
   localparam int REL_LAT   = 2 + DEB_CNT;

   logic             clk_c = 1'b0;
   logic             reset_n_c;
   logic             up_btn_c;
   logic             down_btn_c;
   logic             enable_n_c;
   logic [CNT_W-1:0] level_c = CNT_W'(5);
   logic             up_pulse_c;
   logic             down_pulse_c;
   logic             at_max_c;
   logic             at_min_c;
   logic             lockout_c;

   logic             lvlLoad = 1'b0;
   logic [CNT_W-1:0] lvlVal  = CNT_W'(5);

   int cyc      = 0;
   int errors   = 0;
   int checks   = 0;
   int modelLvl = 5;
   int pushed   = 0;
   int seen     = 0;
   int expTimeQ[$];
   bit expDirQ[$];

   updown_step_ctrl #(
      .DEB_CNT   (DEB_CNT),
      .RPT_DELAY (RPT_DELAY),
      .RPT_RATE  (RPT_RATE),
      .CNT_W     (CNT_W),
      .MAX_VAL   (MAX_VAL),
      .MIN_VAL   (MIN_VAL)
   ) dut (
      .clk_c        (clk_c),
      .reset_n_c    (reset_n_c),
      .up_btn_c     (up_btn_c),
      .down_btn_c   (down_btn_c),
      .enable_n_c   (enable_n_c),
      .level_c      (level_c),
      .up_pulse_c   (up_pulse_c),
      .down_pulse_c (down_pulse_c),
      .at_max_c     (at_max_c),
      .at_min_c     (at_min_c),
      .lockout_c    (lockout_c)
   );

   // 10 ns clock; cyc numbers the interval that follows each rising edge
   always #5 clk_c = ~clk_c;

   always @(posedge clk_c) cyc <= cyc + 1;

   // The counter being controlled: steps on strobes, saturates, can be preloaded
   always @(posedge clk_c) begin
      if (lvlLoad)
         level_c <= lvlVal;
      else if (up_pulse_c && level_c != CNT_W'(MAX_VAL))
         level_c <= level_c + CNT_W'(1);
      else if (down_pulse_c && level_c != CNT_W'(MIN_VAL))
         level_c <= level_c - CNT_W'(1);
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk_c);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   // A step request at cycle t becomes a strobe in cycle t+1 unless the limit blocks it
   task automatic modelRequest(input int t, input bit dir);
      if (!dir && modelLvl < MAX_VAL) begin
         expTimeQ.push_back(t + 1);
         expDirQ.push_back(dir);
         pushed++;
         modelLvl++;
      end else if (dir && modelLvl > MIN_VAL) begin
         expTimeQ.push_back(t + 1);
         expDirQ.push_back(dir);
         pushed++;
         modelLvl--;
      end
   endtask

   // A press starting at cycle p requests steps at p+FIRST_LAT-1, then after
   // RPT_DELAY, then every RPT_RATE, as long as the strobe lands by lastPulse
   task automatic modelPress(input int p, input bit dir, input int lastPulse);
      int t;
      t = p + FIRST_LAT;
      while (t <= lastPulse) begin
         modelRequest(t - 1, dir);
         t = t + ((t == p + FIRST_LAT) ? RPT_DELAY : RPT_RATE);
      end
   endtask

   // Pops one expectation for every strobe the DUT shows
   task automatic monitorLoop();
      int  t;
      bit  d;
      forever begin
         @(negedge clk_c);
         if (up_pulse_c && down_pulse_c) begin
            checks++;
            errors++;
            $display("[TB] FAIL both_pulses: got up=1 down=1, expected at most one (cycle %0d)", cyc);
         end else if (up_pulse_c || down_pulse_c) begin
            seen++;
            checks++;
            if (expTimeQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_pulse: got dir=%0d at cycle %0d, expected no pulse",
                        down_pulse_c, cyc);
            end else begin
               t = expTimeQ.pop_front();
               d = expDirQ.pop_front();
               if (t != cyc || d != down_pulse_c) begin
                  errors++;
                  $display("[TB] FAIL pulse_match: got cycle=%0d dir=%0d, expected cycle=%0d dir=%0d",
                           cyc, down_pulse_c, t, d);
               end
            end
         end
      end
   endtask

   task automatic setBtn(input bit dir, input logic val);
      if (dir) down_btn_c = val;
      else     up_btn_c   = val;
   endtask

   task automatic loadLevel(input int v);
      lvlVal  = CNT_W'(v);
      lvlLoad = 1'b1;
      waitCycles(1);
      lvlLoad  = 1'b0;
      modelLvl = v;
      waitCycles(2);
   endtask

   // Optional short glitch, then a clean press held for holdLen cycles
   task automatic applyStimulus(input bit dir, input int holdLen, input int glitchLen);
      int p;
      if (glitchLen > 0) begin
         setBtn(dir, 1'b1);
         waitCycles(glitchLen);
         setBtn(dir, 1'b0);
         waitCycles(2);
      end
      setBtn(dir, 1'b1);
      p = cyc;
      modelPress(p, dir, p + holdLen + REL_LAT);
      waitCycles(holdLen);
      setBtn(dir, 1'b0);
      waitCycles(16);
   endtask

   initial begin
      int p;
      int q;
      reset_n_c  = 1'b0;
      up_btn_c   = 1'b0;
      down_btn_c = 1'b0;
      enable_n_c = 1'b0;
      lvlLoad    = 1'b1;
      lvlVal     = CNT_W'(5);
      fork
         monitorLoop();
      join_none

      waitCycles(3);
      checkOutput("rst_up_pulse", int'(up_pulse_c), 0);
      checkOutput("rst_down_pulse", int'(down_pulse_c), 0);
      checkOutput("rst_at_max", int'(at_max_c), 0);
      checkOutput("rst_at_min", int'(at_min_c), 0);
      checkOutput("rst_lockout", int'(lockout_c), 0);
      reset_n_c = 1'b1;
      lvlLoad   = 1'b0;
      modelLvl  = 5;
      waitCycles(3);
      checkOutput("mid_flags", int'({at_max_c, at_min_c}), 0);

      $display("[TB] single press with leading glitch");
      applyStimulus(1'b0, 12, 2);
      checkOutput("single_level", int'(level_c), modelLvl);
      checkOutput("single_pulses", seen, pushed);

      $display("[TB] glitch only");
      setBtn(1'b0, 1'b1);
      waitCycles(2);
      setBtn(1'b0, 1'b0);
      waitCycles(16);
      checkOutput("glitch_pulses", seen, pushed);

      $display("[TB] hold-to-repeat down to the floor");
      loadLevel(5);
      applyStimulus(1'b1, 60, 0);
      checkOutput("hold_level", int'(level_c), modelLvl);
      checkOutput("hold_at_min", int'(at_min_c), 1);
      checkOutput("hold_pulses", seen, pushed);

      $display("[TB] upper saturation");
      loadLevel(10);
      applyStimulus(1'b0, 12, 0);
      checkOutput("sat_at_max", int'(at_max_c), 1);
      checkOutput("sat_level", int'(level_c), 10);

      $display("[TB] arbitration: second button during hold");
      loadLevel(5);
      setBtn(1'b0, 1'b1);
      p = cyc;
      modelPress(p, 1'b0, p + 15 + REL_LAT);
      waitCycles(15);
      setBtn(1'b1, 1'b1);
      waitCycles(15);
      checkOutput("arb_lockout", int'(lockout_c), 1);
      up_btn_c   = 1'b0;
      down_btn_c = 1'b0;
      waitCycles(12);
      checkOutput("arb_release", int'(lockout_c), 0);

      $display("[TB] arbitration: both buttons together");
      up_btn_c   = 1'b1;
      down_btn_c = 1'b1;
      waitCycles(15);
      checkOutput("both_lockout", int'(lockout_c), 1);
      up_btn_c   = 1'b0;
      down_btn_c = 1'b0;
      waitCycles(12);
      checkOutput("both_release", int'(lockout_c), 0);

      $display("[TB] enable withdrawn during hold");
      setBtn(1'b1, 1'b1);
      p = cyc;
      modelPress(p, 1'b1, p + 15);
      waitCycles(15);
      enable_n_c = 1'b1;
      waitCycles(5);
      checkOutput("en_lockout", int'(lockout_c), 1);
      enable_n_c = 1'b0;
      waitCycles(30);
      checkOutput("en_still_locked", int'(lockout_c), 1);
      setBtn(1'b1, 1'b0);
      waitCycles(12);
      checkOutput("en_release", int'(lockout_c), 0);

      $display("[TB] reset during hold");
      loadLevel(5);
      setBtn(1'b0, 1'b1);
      p = cyc;
      modelPress(p, 1'b0, p + 14);
      waitCycles(15);
      #2 reset_n_c = 1'b0;
      #1;
      checkOutput("mid_rst_up", int'(up_pulse_c), 0);
      checkOutput("mid_rst_down", int'(down_pulse_c), 0);
      checkOutput("mid_rst_flags", int'({at_max_c, at_min_c}), 0);
      checkOutput("mid_rst_lockout", int'(lockout_c), 0);
      waitCycles(3);
      reset_n_c = 1'b1;
      q = cyc;
      modelPress(q, 1'b0, q + 12 + REL_LAT);
      waitCycles(12);
      setBtn(1'b0, 1'b0);
      waitCycles(16);
      checkOutput("post_rst_level", int'(level_c), modelLvl);
      checkOutput("post_rst_pulses", seen, pushed);

      $display("[TB] randomized presses");
      for (int i = 0; i < 12; i++) begin
         bit dir;
         int lvl;
         int len;
         int gl;
         dir = 1'($urandom_range(0, 1));
         lvl = int'($urandom_range(0, 10));
         len = int'($urandom_range(10, 70));
         gl  = int'($urandom_range(0, 2));
         loadLevel(lvl);
         applyStimulus(dir, len, gl);
         checkOutput("rand_level", int'(level_c), modelLvl);
         checkOutput("rand_at_max", int'(at_max_c), (modelLvl == MAX_VAL) ? 1 : 0);
         checkOutput("rand_at_min", int'(at_min_c), (modelLvl == MIN_VAL) ? 1 : 0);
      end

      waitCycles(5);
      checkOutput("sb_drained", expTimeQ.size(), 0);
      checkOutput("pulse_total", seen, pushed);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
